// File: rtl/alloc_request_controller_if.sv
// Request/response and register-file ports of the allocation request controller.
// The controller sits on the slave modport; the datapath/register files use master.
interface alloc_request_controller_if #(
   parameter int AW = 8
);
   // req_valid/req_ready: a request transfers on a rising edge where both are high;
   // the requester holds req_op/req_class/req_reg stable while req_valid waits for req_ready,
   // and req_valid seen while req_ready is low has no effect.
   logic          req_valid;
   logic          req_ready;
   logic          req_op;
   logic [2:0]    req_class;
   logic [2:0]    req_reg;
   logic [5:0]    rd0, rd1, rd2, rd3, rd4, rd5;
   logic          asr_we;
   logic [2:0]    asr_a;
   logic [5:0]    asr_wd;
   logic [2:0]    sa_a;
   logic [AW-1:0] sa_rd;
   logic          r2a_we;
   logic [2:0]    r2a_regmips;
   logic [AW-1:0] r2a_wd;
   logic          done;
   logic          fail;
   logic [AW-1:0] alloc_addr;

   modport slave (
      input  req_valid, req_op, req_class, req_reg,
      input  rd0, rd1, rd2, rd3, rd4, rd5, sa_rd,
      output req_ready, asr_we, asr_a, asr_wd, sa_a,
      output r2a_we, r2a_regmips, r2a_wd, done, fail, alloc_addr
   );

   modport master (
      output req_valid, req_op, req_class, req_reg,
      output rd0, rd1, rd2, rd3, rd4, rd5, sa_rd,
      input  req_ready, asr_we, asr_a, asr_wd, sa_a,
      input  r2a_we, r2a_regmips, r2a_wd, done, fail, alloc_addr
   );
endinterface

// File: rtl/alloc_request_controller.sv
// Sequences allocate/free requests against the block status rows, the starting-address
// file and the register-to-address table; keeps a private owner table per block.
module alloc_request_controller #(
   parameter int NBLK = 6,
   parameter int AW   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   alloc_request_controller_if.slave     bus,
   output logic [2:0]                    state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_WRITE = 3'd2,
      S_FREE  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    idx_q, blk_q, cls_q, reg_q;
   logic          op_q, fail_q;
   logic [AW-1:0] addr_q;
   logic [NBLK-1:0] own_v;
   logic [2:0]    own_reg [NBLK];

   logic [5:0]    rd [NBLK];
   logic [5:0]    rd_sel;
   logic [7:0]    row_ext;
   logic          can_serve;
   logic          owned_req;
   logic          free_hit;
   logic [2:0]    free_k;
   logic          alloc_ok;

   assign rd[0] = bus.rd0;
   assign rd[1] = bus.rd1;
   assign rd[2] = bus.rd2;
   assign rd[3] = bus.rd3;
   assign rd[4] = bus.rd4;
   assign rd[5] = bus.rd5;

   function automatic logic [5:0] reset_row(input logic [2:0] k);
      case (k)
         3'd0:    return 6'b111110;
         3'd1:    return 6'b111100;
         3'd2:    return 6'b111000;
         3'd3:    return 6'b110000;
         3'd4:    return 6'b100000;
         default: return 6'b000000;
      endcase
   endfunction

   always_comb begin
      rd_sel = 6'h3F;
      case (idx_q)
         3'd0:    rd_sel = rd[0];
         3'd1:    rd_sel = rd[1];
         3'd2:    rd_sel = rd[2];
         3'd3:    rd_sel = rd[3];
         3'd4:    rd_sel = rd[4];
         3'd5:    rd_sel = rd[5];
         default: rd_sel = 6'h3F;
      endcase
   end

   // Padding with ones keeps an out-of-range class from ever looking servable.
   assign row_ext   = {2'b11, rd_sel};
   assign can_serve = !row_ext[cls_q] && (rd_sel != 6'h3F);

   always_comb begin
      owned_req = 1'b0;
      free_hit  = 1'b0;
      free_k    = 3'd0;
      for (int k = 0; k < NBLK; k++) begin
         if (own_v[k] && own_reg[k] == bus.req_reg) owned_req = 1'b1;
         if (!free_hit && own_v[k] && own_reg[k] == reg_q) begin
            free_hit = 1'b1;
            free_k   = 3'(k);
         end
      end
   end

   assign alloc_ok = !bus.req_op && (bus.req_class <= 3'd5) && !owned_req;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Rejected allocates pass through FREE with op_q = 0: that state never writes
   // for them, and it gives every reject the same two-cycle turnaround as a free.
   always_comb begin
      state_d          = state_q;
      bus.req_ready    = 1'b0;
      bus.asr_we       = 1'b0;
      bus.asr_a        = 3'd0;
      bus.asr_wd       = 6'd0;
      bus.sa_a         = 3'd0;
      bus.r2a_we       = 1'b0;
      bus.r2a_regmips  = 3'd0;
      bus.r2a_wd       = '0;
      case (state_q)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = alloc_ok ? S_SCAN : S_FREE;
         end
         S_SCAN: begin
            bus.sa_a = idx_q;
            if (can_serve)                    state_d = S_WRITE;
            else if (idx_q == 3'(NBLK - 1))   state_d = S_DONE;
         end
         S_WRITE: begin
            bus.asr_we      = 1'b1;
            bus.asr_a       = blk_q;
            bus.asr_wd      = 6'h3F;
            bus.sa_a        = blk_q;
            bus.r2a_we      = 1'b1;
            bus.r2a_regmips = reg_q;
            bus.r2a_wd      = bus.sa_rd;
            state_d         = S_DONE;
         end
         S_FREE: begin
            if (op_q && free_hit) begin
               bus.asr_we = 1'b1;
               bus.asr_a  = free_k;
               bus.asr_wd = reset_row(free_k);
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q  <= 3'd0;
         blk_q  <= 3'd0;
         cls_q  <= 3'd0;
         reg_q  <= 3'd0;
         op_q   <= 1'b0;
         fail_q <= 1'b0;
         addr_q <= '0;
         own_v  <= '0;
         for (int k = 0; k < NBLK; k++) own_reg[k] <= 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  op_q   <= bus.req_op;
                  cls_q  <= bus.req_class;
                  reg_q  <= bus.req_reg;
                  idx_q  <= 3'd0;
                  fail_q <= 1'b0;
                  addr_q <= '0;
               end
            end
            S_SCAN: begin
               if (can_serve)                  blk_q  <= idx_q;
               else if (idx_q == 3'(NBLK - 1)) fail_q <= 1'b1;
               else                            idx_q  <= idx_q + 3'd1;
            end
            S_WRITE: begin
               own_v[blk_q]   <= 1'b1;
               own_reg[blk_q] <= reg_q;
               addr_q         <= bus.sa_rd;
            end
            S_FREE: begin
               if (op_q && free_hit) own_v[free_k] <= 1'b0;
               else                  fail_q        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.done       = (state_q == S_DONE);
   assign bus.fail       = bus.done & fail_q;
   assign bus.alloc_addr = bus.done ? addr_q : '0;
   assign state_dbg      = state_q;

endmodule

// File: doc/alloc_request_controller.md
Name: alloc_request_controller

Overview:
- Sequencing FSM directly upstream of the allocation status register file, the starting-address register file and the register-to-address table.
- Accepts allocate and free requests from the MIPS-side datapath.
- Allocate: scans the six blocks for the first free one that can serve the requested size class, marks that block used, and records its starting address against the requesting register.
- Free: returns the block owned by a register to its reset status row.

Parameters:
- NBLK, 6, number of memory blocks / status rows; fixed at 6, since the size classes are 2, 4, 8, 16, 32, 64.
- AW, 8, starting-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  1  0 = allocate, 1 = free
- req_class  in  3  size class 0..5 (2..64 words); 6 and 7 are illegal
- req_reg  in  3  MIPS register that receives or releases the allocation
- rd0..rd5  in  6 each  status rows from the status register file
- asr_we  out  1  status register write enable
- asr_a  out  3  status row index
- asr_wd  out  6  status row write data
- sa_a  out  3  starting-address read index
- sa_rd  in  AW  starting address (combinational read)
- r2a_we  out  1  register-to-address write enable
- r2a_regmips  out  3  target register
- r2a_wd  out  AW  address written
- done  out  1  one-cycle completion pulse
- fail  out  1  valid with done; 1 = request rejected
- alloc_addr  out  AW  valid with done on a successful allocate; 0 otherwise

Behaviour:
- Reset:
  - State returns to IDLE and idx = 0.
  - Owner table is cleared (6 entries of valid + reg[2:0], all invalid).
  - All outputs are 0 except req_ready = 1.
  - Reset mid-operation aborts the operation with no done pulse. The status file resets in the same cycle, so the two stay consistent.
- Block k can serve class c when rd_k[c] == 0 and rd_k != 6'h3F.
- Reset status row for block k is 6'h3F & ~((1<<(k+1))-1), i.e. 111110, 111100, 111000, 110000, 100000, 000000.
- States: IDLE, SCAN, WRITE, FREE, DONE.
- IDLE:
  - req_ready = 1. On req_valid, latch op, class and reg.
  - If op = 0 and (class > 5 or reg already owns a block): go to DONE with fail = 1.
  - If op = 0 otherwise: go to SCAN with idx = 0.
  - If op = 1: go to FREE.
- SCAN, one block per cycle; sa_a = idx:
  - If block idx can serve class: blk <= idx, go to WRITE.
  - Else if idx == 5: go to DONE with fail = 1.
  - Else idx <= idx + 1.
- WRITE, exactly one cycle:
  - asr_we = 1, asr_a = blk, asr_wd = 6'h3F.
  - sa_a = blk.
  - r2a_we = 1, r2a_regmips = reg, r2a_wd = sa_rd.
  - Owner[blk] <= {1, reg}; alloc_addr is latched from sa_rd.
  - Go to DONE.
- FREE, one cycle:
  - If some owner[k] is valid and matches reg: asr_we = 1, asr_a = k, asr_wd = reset row of k; clear owner[k]; fail = 0.
  - Otherwise fail = 1.
  - Go to DONE. reg2address is not written on free.
- DONE: done = 1 for one cycle, fail and alloc_addr held; next state is IDLE.
- Latency: allocate accepted in cycle N with a hit on block k produces done at N+3+k. A failing scan produces done at N+7. Free and illegal requests produce done at N+2.
- req_valid while busy is ignored. At most one write strobe per file per cycle; write strobes are asserted only in WRITE and FREE.

Test Plan:
1. Reset, then allocate class 0, reg 3 at cycle N → WRITE at N+2: asr a=0, wd=3F; r2a reg 3 ← 0x00. done at N+3, fail=0, alloc_addr=0x00.
2. Then allocate class 0, reg 4 → block 0 is full, block 1 hits: r2a reg 4 ← 0x02, done at N+4, alloc_addr=0x02.
3. Allocate class 5, reg 1 → block 5, alloc_addr=0x3E, done at N+8. Repeat with reg 2 → fail=1, done at N+7, no write strobes.
4. Free reg 3 → asr a=0, wd=6'b111110, done at N+2, fail=0. Then allocate class 0, reg 5 → block 0 again, addr 0x00. Free reg 7 (unowned) → fail=1, no write.
5. Allocate class 6 → fail at N+2. Allocate again to a register that already owns a block → fail.
6. Assert reset during SCAN (idx=2) → next cycle IDLE, req_ready=1, no done, owner table empty. The case 1 allocate then succeeds at address 0x00.
